// File: rtl/keypad_entry.sv
// Keypad front end: scans a 4x8 active-low key matrix, debounces whole scan frames,
// shifts hex digits into a 16-bit entry and turns function keys into one-cycle pulses.
module keypad_entry #(
    parameter int unsigned SCAN_DIV = 1024,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [3:0]  row_n,
    input  logic [7:0]  col_n,
    output logic [15:0] userInput,
    output logic        inputValid,
    output logic [2:0]  digits,
    output logic [11:0] fkey
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_MULTI} res_t;
    typedef enum logic {IDLE, PRESSED} state_t;

    logic [CW-1:0] scan_cnt;
    logic [1:0]    row;
    logic [7:0]    col_meta;
    logic [7:0]    col_sync;
    logic          row_last;
    logic          frame_end;

    logic [1:0]    acc_hits;
    logic [4:0]    acc_code;
    logic [1:0]    row_hits;
    logic [2:0]    row_col;
    logic [1:0]    tot_hits;
    logic [4:0]    tot_code;

    res_t          res_kind;
    logic [4:0]    res_code;
    res_t          prev_kind;
    logic [4:0]    prev_code;
    logic [3:0]    stab;
    logic [3:0]    stab_next;
    logic          stable;

    state_t        state;
    state_t        state_next;
    logic          accept;
    logic          acc_digit;
    logic          acc_fkey;
    logic          acc_clr;
    logic [11:0]   fkey_next;

    assign row_last  = (scan_cnt == CW'(SCAN_DIV - 1));
    assign frame_end = row_last && (row == 2'd3);

    always_comb begin
        row_n = ~(4'b0001 << row);
    end

    // Key count per frame saturates at 2 so anything beyond one key reads as MULTI.
    always_comb begin
        row_hits = 2'd0;
        row_col  = 3'd0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!col_sync[i]) begin
                if (row_hits == 2'd0) row_col = 3'(i);
                if (row_hits != 2'd2) row_hits = row_hits + 2'd1;
            end
        end
        tot_hits = acc_hits;
        tot_code = acc_code;
        if (row_hits != 2'd0) begin
            if (acc_hits == 2'd0 && row_hits == 2'd1) begin
                tot_hits = 2'd1;
                tot_code = {row, row_col};
            end else begin
                tot_hits = 2'd2;
            end
        end
    end

    always_comb begin
        res_kind = RES_NONE;
        res_code = '0;
        case (tot_hits)
            2'd0:    res_kind = RES_NONE;
            2'd1: begin
                res_kind = RES_KEY;
                res_code = tot_code;
            end
            default: res_kind = RES_MULTI;
        endcase
        if (res_kind == prev_kind && res_code == prev_code)
            stab_next = (stab == 4'd15) ? stab : stab + 4'd1;
        else
            stab_next = 4'd1;
        stable = (stab_next >= 4'(DEBOUNCE));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt  <= '0;
            row       <= 2'd0;
            col_meta  <= '1;
            col_sync  <= '1;
            acc_hits  <= 2'd0;
            acc_code  <= '0;
            prev_kind <= RES_NONE;
            prev_code <= '0;
            stab      <= 4'd0;
        end else begin
            col_meta <= col_n;
            col_sync <= col_meta;
            if (row_last) begin
                scan_cnt <= '0;
                row      <= row + 2'd1;
                if (row == 2'd3) begin
                    acc_hits  <= 2'd0;
                    acc_code  <= '0;
                    prev_kind <= res_kind;
                    prev_code <= res_code;
                    stab      <= stab_next;
                end else begin
                    acc_hits <= tot_hits;
                    acc_code <= tot_code;
                end
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Only a debounced release leaves PRESSED; other keys and MULTI frames are ignored.
    always_comb begin
        state_next = state;
        if (frame_end) begin
            case (state)
                IDLE:    if (res_kind == RES_KEY && stable) state_next = PRESSED;
                PRESSED: if (res_kind == RES_NONE && stable) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        accept    = frame_end && (state == IDLE) && (res_kind == RES_KEY) && stable;
        acc_digit = accept && !res_code[4];
        acc_fkey  = accept && res_code[4] && (res_code[3:0] <= 4'd11);
        acc_clr   = accept && (res_code == 5'd28);
        fkey_next = '0;
        if (acc_fkey) fkey_next[res_code[3:0]] = 1'b1;
    end

    // A command pulse consumes the entry on the cycle after it is shown.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            userInput  <= '0;
            digits     <= 3'd0;
            inputValid <= 1'b0;
            fkey       <= '0;
        end else begin
            fkey <= fkey_next;
            if (fkey != '0 || acc_clr) begin
                userInput  <= '0;
                digits     <= 3'd0;
                inputValid <= 1'b0;
            end else if (acc_digit) begin
                userInput  <= {userInput[11:0], res_code[3:0]};
                digits     <= (digits == 3'd4) ? digits : digits + 3'd1;
                inputValid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: a key-matrix model drives col_n from row_n and a set of held keys.
module tb_keypad_entry;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  row_n;
    logic [7:0]  col_n;
    logic [15:0] userInput;
    logic        inputValid;
    logic [2:0]  digits;
    logic [11:0] fkey;

    logic [31:0] keys;
    int          compared = 0;
    int          mismatched = 0;
    int          pulse_cnt = 0;

    typedef struct {
        int          code;
        logic [15:0] ui;
        logic [2:0]  dig;
        logic        valid;
    } vec_t;

    vec_t vecs[9];

    keypad_entry #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .row_n      (row_n),
        .col_n      (col_n),
        .userInput  (userInput),
        .inputValid (inputValid),
        .digits     (digits),
        .fkey       (fkey)
    );

    always #5 clk = ~clk;

    always_comb begin
        col_n = '1;
        for (int r = 0; r < 4; r++)
            if (!row_n[r])
                for (int c = 0; c < 8; c++)
                    if (keys[r*8 + c]) col_n[c] = 1'b0;
    end

    always @(negedge clk) begin
        if (fkey != '0) pulse_cnt <= pulse_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic press(input int code, input int down, input int up);
        keys = '0;
        keys[code] = 1'b1;
        tick(down);
        keys = '0;
        tick(up);
    endtask

    initial begin
        int p0;
        int n;
        logic seen;

        vecs[0] = '{1,  16'h0001, 3'd1, 1'b1};
        vecs[1] = '{2,  16'h0012, 3'd2, 1'b1};
        vecs[2] = '{10, 16'h012A, 3'd3, 1'b1};
        vecs[3] = '{11, 16'h12AB, 3'd4, 1'b1};
        vecs[4] = '{5,  16'h2AB5, 3'd4, 1'b1};
        vecs[5] = '{28, 16'h0000, 3'd0, 1'b0};
        vecs[6] = '{15, 16'h000F, 3'd1, 1'b1};
        vecs[7] = '{15, 16'h00FF, 3'd2, 1'b1};
        vecs[8] = '{28, 16'h0000, 3'd0, 1'b0};

        keys  = '0;
        rst_n = 1'b0;
        tick(3);
        check("rst_row_n", 32'(row_n), 32'h0000000E);
        check("rst_userInput", 32'(userInput), 32'h0);
        check("rst_inputValid", 32'(inputValid), 32'h0);
        check("rst_digits", 32'(digits), 32'h0);
        check("rst_fkey", 32'(fkey), 32'h0);

        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic [3:0] exp_row;
            exp_row = ~(4'b0001 << (i % 4));
            check($sformatf("row_seq%0d", i), 32'(row_n), 32'(exp_row));
            tick(4);
        end

        foreach (vecs[i]) begin
            p0 = pulse_cnt;
            press(vecs[i].code, 64, 64);
            check($sformatf("vec%0d_userInput", i), 32'(userInput), 32'(vecs[i].ui));
            check($sformatf("vec%0d_digits", i), 32'(digits), 32'(vecs[i].dig));
            check($sformatf("vec%0d_inputValid", i), 32'(inputValid), 32'(vecs[i].valid));
            check($sformatf("vec%0d_pulses", i), 32'(pulse_cnt - p0), 32'h0);
        end

        // Bounce: key 7 toggles each frame, then holds.
        for (int i = 0; i < 6; i++) begin
            keys = '0;
            keys[7] = (i % 2 == 0);
            tick(16);
        end
        check("bounce_none_userInput", 32'(userInput), 32'h0);
        check("bounce_none_digits", 32'(digits), 32'h0);
        keys = '0;
        keys[7] = 1'b1;
        tick(64);
        check("bounce_userInput", 32'(userInput), 32'h0007);
        check("bounce_digits", 32'(digits), 32'h1);
        keys = '0;
        tick(64);

        // Multi-key sequence.
        keys[3] = 1'b1;
        tick(64);
        check("multi_first", 32'(userInput), 32'h0073);
        keys[4] = 1'b1;
        tick(64);
        keys[3] = 1'b0;
        tick(64);
        check("multi_held_userInput", 32'(userInput), 32'h0073);
        check("multi_held_digits", 32'(digits), 32'h2);
        keys = '0;
        tick(32);
        keys[4] = 1'b1;
        tick(64);
        check("multi_second", 32'(userInput), 32'h0734);
        check("multi_second_digits", 32'(digits), 32'h3);
        keys = '0;
        tick(64);

        // Load command consumes the entry.
        press(28, 64, 64);
        press(0, 64, 64);
        press(2, 64, 64);
        press(0, 64, 64);
        press(0, 64, 64);
        check("load_entry", 32'(userInput), 32'h0200);
        p0 = pulse_cnt;
        keys = '0;
        keys[22] = 1'b1;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 200) begin
            tick(1);
            n++;
            if (fkey != '0) seen = 1'b1;
        end
        check("load_pulse_seen", 32'(seen), 32'h1);
        check("load_fkey", 32'(fkey), 32'h040);
        check("load_pulse_userInput", 32'(userInput), 32'h0200);
        check("load_pulse_inputValid", 32'(inputValid), 32'h1);
        tick(1);
        check("load_after_fkey", 32'(fkey), 32'h0);
        check("load_after_userInput", 32'(userInput), 32'h0);
        check("load_after_inputValid", 32'(inputValid), 32'h0);
        check("load_after_digits", 32'(digits), 32'h0);
        tick(320 - n - 1);
        keys = '0;
        tick(64);
        check("load_one_pulse", 32'(pulse_cnt - p0), 32'h1);

        // Reset while a digit is held.
        press(1, 64, 64);
        press(2, 64, 64);
        check("pre_reset_entry", 32'(userInput), 32'h0012);
        keys[9] = 1'b1;
        tick(8);
        rst_n = 1'b0;
        tick(3);
        check("midrst_userInput", 32'(userInput), 32'h0);
        check("midrst_digits", 32'(digits), 32'h0);
        check("midrst_row_n", 32'(row_n), 32'h0000000E);
        rst_n = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            tick(1);
            n++;
            if (digits != 3'd0) seen = 1'b1;
        end
        check("reaccept_in_time", 32'(seen && n <= 35), 32'h1);
        check("reaccept_userInput", 32'(userInput), 32'h0009);
        keys = '0;
        tick(64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Front-panel keypad front end for the CPU control block. It scans a 4x8 key matrix and debounces it. Hex digits are shifted into a 16-bit entry register. Function keys become single-cycle command pulses. Its outputs drive the CPU control block's `userInput`, `inputValid` and `b_*` button inputs directly.

## Interface
Parameters:
- `SCAN_DIV`, default 1024: clocks each row is driven. Must be at least 4.
- `DEBOUNCE`, default 4: consecutive identical scan frames required to accept a press or a release. Range 1–15.

Ports:
- `clk`, in, 1: system clock. The block uses one clock; everything is synchronous to `clk`.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `row_n`, out, 4: matrix row drive, active-low, one-hot.
- `col_n`, in, 8: matrix column sense, active-low, asynchronous, externally pulled up.
- `userInput`, out, 16: current hex entry.
- `inputValid`, out, 1: high when at least one digit has been entered.
- `digits`, out, 3: number of digits entered, 0–4 (for the display).
- `fkey`, out, 12: function pulses, one cycle wide. Bit assignment:
  - 0 step, 1 reset, 2 runhalt, 3 storeinc
  - 4 irq, 5 dec, 6 load, 7 toA
  - 8 toSP, 9 toX, 10 toY, 11 toPC

## Operation
- **Column sync:** `col_n` passes through a 2-flop synchronizer before any use.
- **Scan:**
  - Row r is driven low for `SCAN_DIV` clocks, then the next row; order 0,1,2,3,0,…
  - Synchronized columns are sampled on the last clock of each row's dwell.
  - A frame is 4 row dwells.
- **Key code** = row*8 + col:
  - codes 0–15: hex digits 0–F (row 0 = 0–7, row 1 = 8–F)
  - codes 16–27: function keys, `fkey` bit = code−16
  - code 28: CLR
  - codes 29–31: unused
- **Frame result:** at the end of each frame, exactly one of:
  - NONE: no key down
  - KEY(code): exactly one key down
  - MULTI: two or more keys down. Unused keys count toward MULTI.
- **Debounce state machine**, states IDLE, PRESSED(code):
  - A stability counter increments when this frame's result equals the last frame's result, otherwise it resets to 1.
  - IDLE → PRESSED(code) when the result is KEY(code) with count ≥ `DEBOUNCE`. This is the accept event; the action fires once.
  - PRESSED → IDLE when the result is NONE with count ≥ `DEBOUNCE`.
  - MULTI frames, and KEY frames of a different code, never change the state and never fire an action.
  - No autorepeat. Pressing the same key again requires a debounced release first.
- **Actions on accept:**
  - Hex digit d: `userInput` ← {`userInput`[11:0], d}; `digits` ← min(`digits`+1, 4). Past 4 digits, the oldest digit is shifted out.
  - Function key k: `fkey`[k] = 1 for exactly one cycle. `userInput`, `inputValid` and `digits` stay unchanged during that cycle. On the following cycle, `userInput`=0, `digits`=0, `inputValid`=0, so the entry is consumed by exactly one command.
  - CLR: `userInput`=0 and `digits`=0 next cycle; no pulse.
  - Unused key: no action.
- `inputValid` = (`digits` != 0), registered together with `digits`.

## Timing
- **Reset values:**
  - `row_n`=4'b1110, `userInput`=0, `inputValid`=0, `digits`=0, `fkey`=0
  - scan counter 0, row 0, debounce state IDLE with count 0, synchronizer flops 1 (idle)
- **Reset mid-operation:** all state clears at the next edge with `rst_n` low. A key held across reset release is accepted again after `DEBOUNCE` frames.
- **Latency:** the accept action becomes visible on the clock after the sample that closes the frame meeting the debounce count. Minimum press-to-action is `DEBOUNCE` full frames plus 3 clocks.
- At most one action per frame. `fkey` never has more than one bit set.

## Test plan
Bench parameters: `SCAN_DIV`=4, `DEBOUNCE`=2.
- **Reset:** `rst_n` low for 3 clocks, then high → all outputs at their reset values; `row_n` cycles 1110, 1101, 1011, 0111 every 4 clocks.
- **Digit entry:** press keys 1, 2, A, B, 5 in turn, each held for 4 frames and released for 4 frames → `userInput` goes 0001, 0012, 012A, 12AB, 2AB5; `digits` goes 1, 2, 3, 4, 4; `inputValid`=1.
- **Load command:** enter 0x0200, then press code 22 (load) → `fkey`=0x040 for exactly one cycle with `userInput`=0x0200 and `inputValid`=1; next cycle `userInput`=0 and `inputValid`=0. Holding the key for 20 frames produces only one pulse.
- **Bounce:** key 7 toggles every frame for 6 frames, then holds → no action until 2 stable frames; then exactly one digit 7 is accepted.
- **Multi-key:** hold 3, add 4 while 3 is held, release 3 while 4 is held → only 3 is accepted. After releasing everything for 2 frames and pressing 4 again → 4 is accepted.
- **CLR and reset:**
  - Enter F, F, then CLR → `userInput`=0 and `digits`=0, `fkey` stays 0.
  - Assert reset while digit 9 is held and 2 digits are entered → entry is 0. After release of reset, 9 is re-accepted within 2 frames plus 3 clocks.
